// File: rtl/dcache_req_arb.sv
// Small owner FIFO: remembers which upstream port each in-flight cache request belongs to.
// Latency: head is visible combinationally; push/pop take effect on the next rising edge.
// Backpressure: none internally; the caller pushes only when !full or when popping in the same cycle.
module dcache_req_arb_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

// Two-port round-robin arbiter in front of a data cache, with in-order response routing.
// Latency: request path and response path are both combinational (zero cycles).
// Backpressure: grant locks while the cache stalls; issue stops when the owner FIFO is full unless a response frees a slot.
module dcache_req_arb #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_LENGTH = 32,
    parameter int OWN_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   p0_req_valid,
    input  logic                   p0_req_write,
    input  logic [ADDR_LENGTH-1:0] p0_req_addr,
    input  logic [WORD_SIZE-1:0]   p0_req_wdata,
    input  logic [2:0]             p0_req_size,
    output logic                   p0_req_ready,
    output logic                   p0_resp_valid,
    output logic [WORD_SIZE-1:0]   p0_resp_rdata,
    input  logic                   p1_req_valid,
    input  logic                   p1_req_write,
    input  logic [ADDR_LENGTH-1:0] p1_req_addr,
    input  logic [WORD_SIZE-1:0]   p1_req_wdata,
    input  logic [2:0]             p1_req_size,
    output logic                   p1_req_ready,
    output logic                   p1_resp_valid,
    output logic [WORD_SIZE-1:0]   p1_resp_rdata,
    output logic                   c_req_valid,
    output logic [ADDR_LENGTH-1:0] c_req_addr,
    output logic [WORD_SIZE-1:0]   c_req_wdata,
    output logic                   c_req_write,
    output logic [2:0]             c_req_size,
    input  logic                   c_req_ready,
    input  logic                   c_resp_valid,
    input  logic [WORD_SIZE-1:0]   c_resp_rdata,
    output logic                   err_spurious
);
    logic rr_ptr;
    logic lock_q;
    logic lock_port_q;
    logic gnt_vld;
    logic gnt;
    logic can_issue;
    logic own_full;
    logic own_empty;
    logic own_head;
    logic push;
    logic pop;

    // Pick the port to present downstream: a stalled grant is held, otherwise round-robin.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        if (lock_q) begin
            gnt_vld = 1'b1;
            gnt     = lock_port_q;
        end else if (p0_req_valid && p1_req_valid) begin
            gnt_vld = 1'b1;
            gnt     = rr_ptr;
        end else if (p0_req_valid) begin
            gnt_vld = 1'b1;
            gnt     = 1'b0;
        end else if (p1_req_valid) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
        end
    end

    // A response in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_issue   = !own_full || c_resp_valid;
    assign c_req_valid = gnt_vld && can_issue;
    assign push        = c_req_valid && c_req_ready;
    assign pop         = c_resp_valid && !own_empty;

    // Downstream request fields: mux of the granted port, zero when nothing is issued.
    always_comb begin
        c_req_addr  = '0;
        c_req_wdata = '0;
        c_req_write = 1'b0;
        c_req_size  = 3'd0;
        if (c_req_valid) begin
            if (gnt) begin
                c_req_addr  = p1_req_addr;
                c_req_wdata = p1_req_wdata;
                c_req_write = p1_req_write;
                c_req_size  = p1_req_size;
            end else begin
                c_req_addr  = p0_req_addr;
                c_req_wdata = p0_req_wdata;
                c_req_write = p0_req_write;
                c_req_size  = p0_req_size;
            end
        end
    end

    assign p0_req_ready = c_req_valid && (gnt == 1'b0) && c_req_ready;
    assign p1_req_ready = c_req_valid && (gnt == 1'b1) && c_req_ready;

    // Responses return in issue order; the FIFO head names the owner.
    assign p0_resp_valid = pop && (own_head == 1'b0);
    assign p1_resp_valid = pop && (own_head == 1'b1);
    assign p0_resp_rdata = p0_resp_valid ? c_resp_rdata : '0;
    assign p1_resp_rdata = p1_resp_valid ? c_resp_rdata : '0;

    dcache_req_arb_fifo #(
        .WIDTH (1),
        .DEPTH (OWN_DEPTH)
    ) u_own_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (gnt),
        .pop      (pop),
        .head_dat (own_head),
        .full     (own_full),
        .empty    (own_empty)
    );

    // Round-robin pointer, stall lock and sticky spurious-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b0;
            lock_q       <= 1'b0;
            lock_port_q  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= ~gnt;
                lock_q <= 1'b0;
            end else if (c_req_valid) begin
                lock_q      <= 1'b1;
                lock_port_q <= gnt;
            end
            if (c_resp_valid && own_empty) begin
                err_spurious <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_req_arb.sv
module tb_dcache_req_arb;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_valid, p0_req_write, p0_req_ready, p0_resp_valid;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
    logic [2:0]  p0_req_size;
    logic        p1_req_valid, p1_req_write, p1_req_ready, p1_resp_valid;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
    logic [2:0]  p1_req_size;
    logic        c_req_valid, c_req_write, c_req_ready, c_resp_valid, err_spurious;
    logic [31:0] c_req_addr, c_req_wdata, c_resp_rdata;
    logic [2:0]  c_req_size;

    int checks = 0;
    int errors = 0;
    bit own_q[$];

    typedef struct packed {
        logic       v0, v1, crdy, crv;
        logic [1:0] sel;
        logic       r0, r1, spur;
    } vec_t;

    vec_t vecs[21];

    always #5 clk = ~clk;

    dcache_req_arb dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_write(p0_req_write), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_size(p0_req_size), .p0_req_ready(p0_req_ready),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_write(p1_req_write), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_size(p1_req_size), .p1_req_ready(p1_req_ready),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .c_req_valid(c_req_valid), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_req_write(c_req_write), .c_req_size(c_req_size), .c_req_ready(c_req_ready),
        .c_resp_valid(c_resp_valid), .c_resp_rdata(c_resp_rdata), .err_spurious(err_spurious)
    );

    function automatic vec_t mk(input logic v0, v1, crdy, crv, input logic [1:0] sel,
                                input logic r0, r1, spur);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.crdy = crdy; v.crv = crv;
        v.sel = sel; v.r0 = r0; v.r1 = r1; v.spur = spur;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected downstream fields for a given selection (0 none, 1 port0, 2 port1).
    task automatic chk_creq(input string tag, input logic [1:0] sel);
        logic [31:0] ea;
        logic [35:0] ef;
        ea = (sel == 2'd1) ? A0 : (sel == 2'd2) ? A1 : 32'h0;
        ef = (sel == 2'd1) ? {1'b0, 3'd2, D0} : (sel == 2'd2) ? {1'b1, 3'd3, D1} : 36'h0;
        chk({tag, " c_req_valid"}, 64'(c_req_valid), 64'(sel != 2'd0));
        chk({tag, " c_req_addr"}, 64'(c_req_addr), 64'(ea));
        chk({tag, " c_req_fields"}, 64'({c_req_write, c_req_size, c_req_wdata}), 64'(ef));
    endtask

    // One cycle: drive inputs, check outputs at the falling edge, update the owner scoreboard.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        logic  e0, e1;
        logic [31:0] rd;
        bit own;
        tag = $sformatf("row%0d", idx);
        rd  = 32'hD000_0000 + 32'(idx);
        p0_req_valid = v.v0;
        p1_req_valid = v.v1;
        c_req_ready  = v.crdy;
        c_resp_valid = v.crv;
        c_resp_rdata = rd;
        @(negedge clk);
        chk_creq(tag, v.sel);
        chk({tag, " p0_req_ready"}, 64'(p0_req_ready), 64'(v.r0));
        chk({tag, " p1_req_ready"}, 64'(p1_req_ready), 64'(v.r1));
        chk({tag, " err_spurious"}, 64'(err_spurious), 64'(v.spur));
        e0 = 1'b0;
        e1 = 1'b0;
        if (v.crv && own_q.size() > 0) begin
            own = own_q.pop_front();
            e0 = (own == 1'b0);
            e1 = (own == 1'b1);
        end
        chk({tag, " p0_resp_valid"}, 64'(p0_resp_valid), 64'(e0));
        chk({tag, " p1_resp_valid"}, 64'(p1_resp_valid), 64'(e1));
        chk({tag, " p0_resp_rdata"}, 64'(p0_resp_rdata), e0 ? 64'(rd) : 64'h0);
        chk({tag, " p1_resp_rdata"}, 64'(p1_resp_rdata), e1 ? 64'(rd) : 64'h0);
        if (v.r0) own_q.push_back(1'b0);
        if (v.r1) own_q.push_back(1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stimulus table: fields v0 v1 crdy crv | sel r0 r1 spur
        vecs[0]  = mk(1,1,1,0, 2'd1, 1,0, 0); // both valid, rr=0 -> p0
        vecs[1]  = mk(1,1,1,1, 2'd2, 0,1, 0); // alternate to p1, resp to p0
        vecs[2]  = mk(1,1,1,1, 2'd1, 1,0, 0);
        vecs[3]  = mk(1,1,1,1, 2'd2, 0,1, 0);
        vecs[4]  = mk(0,0,1,1, 2'd0, 0,0, 0); // drain last resp to p1
        vecs[5]  = mk(0,1,1,0, 2'd2, 0,1, 0); // only p1 valid with rr=0
        vecs[6]  = mk(1,1,1,1, 2'd1, 1,0, 0); // rr back at 0 -> p0
        vecs[7]  = mk(0,0,0,1, 2'd0, 0,0, 0);
        vecs[8]  = mk(1,0,0,0, 2'd1, 0,0, 0); // p0 stalls, lock
        vecs[9]  = mk(1,1,0,0, 2'd1, 0,0, 0); // rr=1 but lock holds p0
        vecs[10] = mk(1,1,0,0, 2'd1, 0,0, 0);
        vecs[11] = mk(1,1,1,0, 2'd1, 1,0, 0); // p0 accepted
        vecs[12] = mk(0,1,1,0, 2'd2, 0,1, 0); // p1 next, FIFO now full
        vecs[13] = mk(0,1,1,0, 2'd0, 0,0, 0); // full: no issue
        vecs[14] = mk(0,1,1,0, 2'd0, 0,0, 0);
        vecs[15] = mk(0,1,1,1, 2'd2, 0,1, 0); // resp frees slot, p1 accepted
        vecs[16] = mk(0,0,1,1, 2'd0, 0,0, 0);
        vecs[17] = mk(0,0,1,1, 2'd0, 0,0, 0);
        vecs[18] = mk(0,0,0,1, 2'd0, 0,0, 0); // spurious response
        vecs[19] = mk(0,0,0,0, 2'd0, 0,0, 1);
        vecs[20] = mk(0,0,0,0, 2'd0, 0,0, 1);

        rst_n = 1'b0;
        p0_req_valid = 0; p0_req_write = 1'b0; p0_req_addr = A0; p0_req_wdata = D0; p0_req_size = 3'd2;
        p1_req_valid = 0; p1_req_write = 1'b1; p1_req_addr = A1; p1_req_wdata = D1; p1_req_size = 3'd3;
        c_req_ready = 0; c_resp_valid = 0; c_resp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset c_req_valid", 64'(c_req_valid), 64'h0);
        chk("reset err_spurious", 64'(err_spurious), 64'h0);
        chk("reset resp_valid", 64'({p0_resp_valid, p1_resp_valid}), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], i);
        end

        // One owner outstanding (p0 wins, rr moves to 1), then reset mid-transaction.
        apply(mk(1,1,1,0, 2'd1, 1,0, 1), 21);
        rst_n = 1'b0;
        own_q.delete();
        p0_req_valid = 1'b0; p1_req_valid = 1'b1; c_req_ready = 1'b0;
        c_resp_valid = 1'b1; c_resp_rdata = 32'hBAD0_0001;
        #1;
        chk_creq("inrst p1only", 2'd2);
        chk("inrst resp_valid", 64'({p0_resp_valid, p1_resp_valid}), 64'h0);
        chk("inrst err_spurious", 64'(err_spurious), 64'h0);
        p0_req_valid = 1'b1;
        #1;
        chk_creq("inrst both", 2'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(0,0,0,1, 2'd0, 0,0, 0), 22); // response after reset is spurious
        apply(mk(1,1,1,0, 2'd1, 1,0, 1), 23); // rr reset to 0 -> p0
        apply(mk(0,0,0,1, 2'd0, 0,0, 1), 24); // response routes to p0

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
